// File: rtl/clock_pkg.sv
// Shared types and digit geometry for the BCD time-of-day counter.
package clock_pkg;

    typedef enum logic {
        RUN = 1'b0,
        SET = 1'b1
    } state_t;

    localparam int SEC_TENS_W  = 3;
    localparam int SEC_ONES_W  = 4;
    localparam int MIN_TENS_W  = 3;
    localparam int MIN_ONES_W  = 4;
    localparam int HOUR_TENS_W = 2;
    localparam int HOUR_ONES_W = 4;
    localparam int ONES_W      = 4;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps to 00 after TENS_MAX/ONES_TOP; one cycle update latency.
// wrap is combinational from inc so carries ripple into the next counter in the same cycle.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int TENS_W   = 3,
    parameter int TENS_MAX = 5,
    parameter int ONES_TOP = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              clear,
    output logic [TENS_W-1:0] tens,
    output logic [ONES_W-1:0] ones,
    output logic              wrap
);

    logic at_top;
    logic ones_nine;

    assign at_top    = (tens == TENS_W'(TENS_MAX)) && (ones == ONES_W'(ONES_TOP));
    assign ones_nine = (ones == ONES_W'(9));
    assign wrap      = inc & at_top & ~clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens <= '0;
            ones <= '0;
        end else if (clear) begin
            tens <= '0;
            ones <= '0;
        end else if (inc) begin
            if (at_top) begin
                tens <= '0;
                ones <= '0;
            end else if (ones_nine) begin
                tens <= tens + TENS_W'(1);
                ones <= '0;
            end else begin
                ones <= ones + ONES_W'(1);
            end
        end
    end

endmodule

// File: rtl/time_keeper.sv
// 24-hour BCD time-of-day counter driven by 1 Hz edges, with a SET mode for button adjustment.
// All outputs registered; a 1 Hz rising edge sampled at edge N shows on the digits after edge N.
module time_keeper
    import clock_pkg::*;
#(
    parameter bit CLEAR_SEC_ON_SET = 1'b1
) (
    input  logic                   clock_high_hz,
    input  logic                   reset_n,
    input  logic                   clock_1hz,
    input  logic                   set_mode,
    input  logic                   inc_min,
    input  logic                   inc_hour,
    output logic [SEC_TENS_W-1:0]  sec_tens,
    output logic [SEC_ONES_W-1:0]  sec_ones,
    output logic [MIN_TENS_W-1:0]  min_tens,
    output logic [MIN_ONES_W-1:0]  min_ones,
    output logic [HOUR_TENS_W-1:0] hour_tens,
    output logic [HOUR_ONES_W-1:0] hour_ones,
    output logic                   second_tick,
    output logic                   day_rollover,
    output logic                   setting
);

    state_t state;
    logic   clk1_q;
    logic   tick;
    logic   run_tick;
    logic   enter_set;
    logic   in_set;
    logic   sec_wrap;
    logic   min_wrap;
    logic   hour_wrap;
    logic   min_inc;
    logic   hour_inc;

    // Ticks on a mode-change cycle are dropped: RUN with set_mode high is already leaving.
    assign tick      = clock_1hz & ~clk1_q;
    assign in_set    = (state == SET);
    assign run_tick  = tick & (state == RUN) & ~set_mode;
    assign enter_set = (state == RUN) & set_mode;
    assign min_inc   = (run_tick & sec_wrap) | (in_set & inc_min);
    assign hour_inc  = (run_tick & sec_wrap & min_wrap) | (in_set & inc_hour);

    bcd_mod_counter #(
        .TENS_W  (SEC_TENS_W),
        .TENS_MAX(SEC_MAX / 10),
        .ONES_TOP(SEC_MAX % 10)
    ) u_sec (
        .clk  (clock_high_hz),
        .rst_n(reset_n),
        .inc  (run_tick),
        .clear(enter_set & CLEAR_SEC_ON_SET),
        .tens (sec_tens),
        .ones (sec_ones),
        .wrap (sec_wrap)
    );

    bcd_mod_counter #(
        .TENS_W  (MIN_TENS_W),
        .TENS_MAX(MIN_MAX / 10),
        .ONES_TOP(MIN_MAX % 10)
    ) u_min (
        .clk  (clock_high_hz),
        .rst_n(reset_n),
        .inc  (min_inc),
        .clear(1'b0),
        .tens (min_tens),
        .ones (min_ones),
        .wrap (min_wrap)
    );

    bcd_mod_counter #(
        .TENS_W  (HOUR_TENS_W),
        .TENS_MAX(HOUR_MAX / 10),
        .ONES_TOP(HOUR_MAX % 10)
    ) u_hour (
        .clk  (clock_high_hz),
        .rst_n(reset_n),
        .inc  (hour_inc),
        .clear(1'b0),
        .tens (hour_tens),
        .ones (hour_ones),
        .wrap (hour_wrap)
    );

    // clk1_q resets high so a 1 Hz level already high at release is not seen as an edge.
    always_ff @(posedge clock_high_hz or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RUN;
            setting      <= 1'b0;
            second_tick  <= 1'b0;
            day_rollover <= 1'b0;
            clk1_q       <= 1'b1;
        end else begin
            clk1_q       <= clock_1hz;
            second_tick  <= run_tick;
            day_rollover <= run_tick & sec_wrap & min_wrap & hour_wrap;
            case (state)
                RUN: begin
                    if (set_mode) begin
                        state   <= SET;
                        setting <= 1'b1;
                    end
                end
                SET: begin
                    if (!set_mode) begin
                        state   <= RUN;
                        setting <= 1'b0;
                    end
                end
                default: begin
                    state   <= RUN;
                    setting <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_keeper.sv
// Directed self-checking bench for time_keeper: counting, rollover, SET adjustment and reset.
module tb_time_keeper;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clock_1hz;
    logic       set_mode;
    logic       inc_min;
    logic       inc_hour;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [1:0] hour_tens;
    logic [3:0] hour_ones;
    logic       second_tick;
    logic       day_rollover;
    logic       setting;

    int total = 0;
    int bad   = 0;
    int tick_cnt = 0;
    int roll_cnt = 0;

    logic [23:0] disp;
    assign disp = {2'b00, hour_tens, hour_ones, 1'b0, min_tens, min_ones, 1'b0, sec_tens, sec_ones};

    time_keeper #(.CLEAR_SEC_ON_SET(1'b1)) dut (
        .clock_high_hz(clk),
        .reset_n      (reset_n),
        .clock_1hz    (clock_1hz),
        .set_mode     (set_mode),
        .inc_min      (inc_min),
        .inc_hour     (inc_hour),
        .sec_tens     (sec_tens),
        .sec_ones     (sec_ones),
        .min_tens     (min_tens),
        .min_ones     (min_ones),
        .hour_tens    (hour_tens),
        .hour_ones    (hour_ones),
        .second_tick  (second_tick),
        .day_rollover (day_rollover),
        .setting      (setting)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n) begin
            if (second_tick) tick_cnt++;
            if (day_rollover) roll_cnt++;
        end
    end

    function automatic logic [23:0] bcd(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic one_edge();
        clock_1hz = 1'b1;
        repeat (2) @(negedge clk);
        clock_1hz = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) one_edge();
    endtask

    task automatic pulse(input logic do_min, input logic do_hour, input int n);
        for (int i = 0; i < n; i++) begin
            inc_min  = do_min;
            inc_hour = do_hour;
            @(negedge clk);
            inc_min  = 1'b0;
            inc_hour = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic mode(input logic m);
        set_mode = m;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clock_1hz = 1'b1;
        set_mode  = 1'b0;
        inc_min   = 1'b0;
        inc_hour  = 1'b0;
        reset_n   = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({disp, setting, second_tick, day_rollover} !== 27'd0) begin
            bad++;
            $display("FAIL reset_state: got %h/%b%b%b want 000000/000", disp, setting, second_tick, day_rollover);
        end
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (disp !== bcd(0, 0, 0) || tick_cnt !== 0) begin
            bad++;
            $display("FAIL reset_high_1hz: got %h ticks=%0d want 000000 ticks=0", disp, tick_cnt);
        end
        clock_1hz = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_count();
        tick_cnt = 0;
        roll_cnt = 0;
        clock_1hz = 1'b1;
        @(negedge clk);
        total++;
        if (second_tick !== 1'b1 || disp !== bcd(0, 0, 1)) begin
            bad++;
            $display("FAIL tick_latency: got tick=%b %h want tick=1 000001", second_tick, disp);
        end
        @(negedge clk);
        total++;
        if (second_tick !== 1'b0) begin
            bad++;
            $display("FAIL tick_width: got %b want 0", second_tick);
        end
        clock_1hz = 1'b0;
        repeat (2) @(negedge clk);
        edges(60);
        total++;
        if (disp !== bcd(0, 1, 1) || tick_cnt !== 61 || roll_cnt !== 0) begin
            bad++;
            $display("FAIL count_61: got %h ticks=%0d rolls=%0d want 000101 ticks=61 rolls=0", disp, tick_cnt, roll_cnt);
        end
    endtask

    task automatic test_rollover();
        mode(1'b1);
        total++;
        if (setting !== 1'b1 || disp !== bcd(0, 1, 0)) begin
            bad++;
            $display("FAIL set_entry: got setting=%b %h want 1 000100", setting, disp);
        end
        pulse(1'b0, 1'b1, 23);
        pulse(1'b1, 1'b0, 58);
        mode(1'b0);
        total++;
        if (setting !== 1'b0 || disp !== bcd(23, 59, 0)) begin
            bad++;
            $display("FAIL preload: got setting=%b %h want 0 235900", setting, disp);
        end
        edges(58);
        tick_cnt = 0;
        roll_cnt = 0;
        one_edge();
        total++;
        if (disp !== bcd(23, 59, 59) || roll_cnt !== 0) begin
            bad++;
            $display("FAIL at_235959: got %h rolls=%0d want 235959 rolls=0", disp, roll_cnt);
        end
        clock_1hz = 1'b1;
        @(negedge clk);
        total++;
        if (disp !== bcd(0, 0, 0) || second_tick !== 1'b1 || day_rollover !== 1'b1) begin
            bad++;
            $display("FAIL day_wrap: got %h tick=%b roll=%b want 000000 1 1", disp, second_tick, day_rollover);
        end
        @(negedge clk);
        clock_1hz = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (roll_cnt !== 1 || tick_cnt !== 2) begin
            bad++;
            $display("FAIL roll_count: got rolls=%0d ticks=%0d want 1 2", roll_cnt, tick_cnt);
        end
    endtask

    task automatic test_set_adjust();
        mode(1'b1);
        pulse(1'b0, 1'b1, 12);
        pulse(1'b1, 1'b0, 34);
        mode(1'b0);
        edges(56);
        total++;
        if (disp !== bcd(12, 34, 56)) begin
            bad++;
            $display("FAIL run_to_123456: got %h want 123456", disp);
        end
        mode(1'b1);
        total++;
        if (disp !== bcd(12, 34, 0)) begin
            bad++;
            $display("FAIL clear_sec: got %h want 123400", disp);
        end
        pulse(1'b1, 1'b0, 26);
        total++;
        if (disp !== bcd(12, 0, 0)) begin
            bad++;
            $display("FAIL min_wrap_set: got %h want 120000", disp);
        end
        tick_cnt = 0;
        roll_cnt = 0;
        edges(3);
        total++;
        if (disp !== bcd(12, 0, 0) || tick_cnt !== 0) begin
            bad++;
            $display("FAIL set_ignores_tick: got %h ticks=%0d want 120000 ticks=0", disp, tick_cnt);
        end
        pulse(1'b0, 1'b1, 12);
        total++;
        if (disp !== bcd(0, 0, 0) || roll_cnt !== 0) begin
            bad++;
            $display("FAIL hour_wrap_set: got %h rolls=%0d want 000000 rolls=0", disp, roll_cnt);
        end
        mode(1'b0);
    endtask

    task automatic test_ignore_and_both();
        pulse(1'b1, 1'b1, 2);
        total++;
        if (disp !== bcd(0, 0, 0)) begin
            bad++;
            $display("FAIL run_ignores_inc: got %h want 000000", disp);
        end
        mode(1'b1);
        pulse(1'b0, 1'b1, 9);
        pulse(1'b1, 1'b0, 59);
        pulse(1'b1, 1'b1, 1);
        total++;
        if (disp !== bcd(10, 0, 0)) begin
            bad++;
            $display("FAIL both_inc: got %h want 100000", disp);
        end
        mode(1'b0);
    endtask

    task automatic test_mode_change();
        tick_cnt = 0;
        set_mode  = 1'b1;
        clock_1hz = 1'b1;
        @(negedge clk);
        clock_1hz = 1'b0;
        repeat (3) @(negedge clk);
        set_mode  = 1'b0;
        clock_1hz = 1'b1;
        @(negedge clk);
        clock_1hz = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (disp !== bcd(10, 0, 0) || tick_cnt !== 0 || setting !== 1'b0) begin
            bad++;
            $display("FAIL mode_edge_drop: got %h ticks=%0d setting=%b want 100000 0 0", disp, tick_cnt, setting);
        end
        one_edge();
        total++;
        if (disp !== bcd(10, 0, 1) || tick_cnt !== 1) begin
            bad++;
            $display("FAIL first_after_set: got %h ticks=%0d want 100001 1", disp, tick_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        mode(1'b1);
        pulse(1'b0, 1'b1, 5);
        pulse(1'b1, 1'b0, 17);
        mode(1'b0);
        edges(42);
        total++;
        if (disp !== bcd(5, 17, 42)) begin
            bad++;
            $display("FAIL pre_reset_time: got %h want 051742", disp);
        end
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (disp !== bcd(0, 0, 0) || setting !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got %h setting=%b want 000000 0", disp, setting);
        end
        @(negedge clk);
        reset_n = 1'b1;
        mode(1'b1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (setting !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_set: got setting=%b want 0", setting);
        end
        @(negedge clk);
        set_mode = 1'b0;
        reset_n  = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_count();
        test_rollover();
        test_set_adjust();
        test_ignore_and_both();
        test_mode_change();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
